// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtract cell walks the operands while a registered borrow carries
// between bit positions.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, bin); in_ready only in IDLE
//   a, b, bin             minuend, subtrahend, borrow-in
//   out_valid / out_ready result handshake; out_valid only in DONE
//   diff, bout            a - b - bin modulo 2^WIDTH, final borrow (a < b + bin)
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   ra;
    logic [WIDTH-1:0]   rb;
    logic [WIDTH-1:0]   rd;
    logic               borrow;
    logic               cell_d;
    logic               cell_bo;
    logic               last_bit;

    // Full-subtract cell on the current LSBs and the running borrow.
    always_comb begin
        cell_d   = ra[0] ^ rb[0] ^ borrow;
        cell_bo  = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & borrow);
        last_bit = (cnt == CNT_W'(WIDTH - 1));
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SHIFT;
            SHIFT:   if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
        end
    end

    // Datapath: operand capture, serial shift, result/borrow accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra     <= '0;
            rb     <= '0;
            rd     <= '0;
            borrow <= 1'b0;
            bout   <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra     <= a;
                        rb     <= b;
                        borrow <= bin;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    rd     <= {cell_d, rd[WIDTH-1:1]};
                    ra     <= ra >> 1;
                    rb     <= rb >> 1;
                    borrow <= cell_bo;
                    if (last_bit) begin
                        cnt  <= '0;
                        // bout mirrors the borrow only once the result is final.
                        bout <= cell_bo;
                    end else begin
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = rd;

endmodule
